// File: rtl/tdm_burst_mux.sv
// Time-division burst multiplexer: each of NUM_CH channels owns a SLOT_LEN-cycle slot, with
// GUARD_LEN idle cycles between slots. Define TDM_IDLE_FILL_EN to emit zero fill words.
module tdm_burst_mux #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SLOT_LEN   = 8,
    parameter int unsigned GUARD_LEN  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    input  logic [NUM_CH-1:0]            din_valid,
    output logic [NUM_CH-1:0]            din_ready,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         dout_valid,
    output logic [$clog2(NUM_CH)-1:0]    dout_ch,
    output logic                         frame_start
);
    localparam int unsigned ChW = $clog2(NUM_CH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSlot  = 2'd1;
    localparam logic [1:0] StGuard = 2'd2;

    localparam logic [7:0]     SlotLast  = 8'(SLOT_LEN - 1);
    localparam logic [7:0]     GuardLast = 8'(GUARD_LEN - 1);
    localparam logic [ChW-1:0] ChLast    = ChW'(NUM_CH - 1);

    logic [1:0]            state_q, state_d;
    logic [ChW-1:0]        ch_q, ch_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [ChW-1:0]        dout_ch_q, dout_ch_d;
    logic                  frame_start_q, frame_start_d;

    logic                  in_slot;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_word;
    logic [1:0]            adv_state;
    logic [ChW-1:0]        adv_ch;

    assign in_slot = (state_q == StSlot);

    always_comb begin
        sel_word  = '0;
        din_ready = '0;
        xfer      = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_q == ChW'(i)) begin
                sel_word     = din[i*DATA_WIDTH +: DATA_WIDTH];
                din_ready[i] = in_slot;
                xfer         = in_slot && din_valid[i];
            end
        end
    end

    // Move to the next slot; en is only honoured at the end of the last slot (or its guard).
    always_comb begin
        if (ch_q == ChLast) begin
            adv_ch    = '0;
            adv_state = en ? StSlot : StIdle;
        end else begin
            adv_ch    = ch_q + ChW'(1);
            adv_state = StSlot;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StSlot;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            end
            StSlot: begin
                if (cnt_q == SlotLast) begin
                    cnt_d = '0;
                    if (GUARD_LEN != 0) begin
                        state_d = StGuard;
                    end else begin
                        state_d = adv_state;
                        ch_d    = adv_ch;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGuard: begin
                if (cnt_q == GuardLast) begin
                    cnt_d   = '0;
                    state_d = adv_state;
                    ch_d    = adv_ch;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                ch_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        dout_ch_d     = dout_ch_q;
        frame_start_d = 1'b0;
        if (in_slot) begin
            dout_ch_d     = ch_q;
            frame_start_d = (ch_q == '0) && (cnt_q == '0);
            if (xfer) begin
                dout_d       = sel_word;
                dout_valid_d = 1'b1;
            end
`ifdef TDM_IDLE_FILL_EN
            else begin
                dout_d       = '0;
                dout_valid_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ch_q          <= '0;
            cnt_q         <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_ch_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            dout_ch_q     <= dout_ch_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_ch     = dout_ch_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_tdm_burst_mux.sv
// Bench for tdm_burst_mux: default instance checked against a frame-position scoreboard,
// plus a NUM_CH=2/SLOT_LEN=1/GUARD_LEN=0 instance for back-to-back slots.
module tb_tdm_burst_mux;
    localparam int NCH = 4;
    localparam int SL  = 8;
    localparam int GL  = 1;
    localparam int P   = SL + GL;
    localparam int F   = NCH * P;
`ifdef TDM_IDLE_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] din = '0;
    logic [3:0]  din_valid = '0;
    logic [3:0]  din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [1:0]  dout_ch;
    logic        frame_start;

    logic        en2 = 1'b0;
    logic [15:0] din2 = 16'h1110;
    logic [1:0]  din_valid2 = '0;
    logic [1:0]  din_ready2;
    logic [7:0]  dout2;
    logic        dout_valid2;
    logic        dout_ch2;
    logic        frame_start2;

    always #5 clk = ~clk;

    tdm_burst_mux u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ch     (dout_ch),
        .frame_start (frame_start)
    );

    tdm_burst_mux #(
        .DATA_WIDTH (8),
        .NUM_CH     (2),
        .SLOT_LEN   (1),
        .GUARD_LEN  (0)
    ) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en2),
        .din         (din2),
        .din_valid   (din_valid2),
        .din_ready   (din_ready2),
        .dout        (dout2),
        .dout_valid  (dout_valid2),
        .dout_ch     (dout_ch2),
        .frame_start (frame_start2)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] ch;
        logic       fs;
    } exp_t;

    typedef struct {
        string      name;
        logic       en;
        logic [3:0] valid;
        logic [7:0] base;
        int         cycles;
        int         exp_nvalid;
        int         exp_nfs;
    } phase_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   obs_valid;
    int   obs_fs;

    // Reference model: position within the frame, derived from slot/guard lengths.
    int         m_active = 0;
    int         m_pos    = 0;
    logic [7:0] m_dout   = '0;
    logic [1:0] m_ch     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pos    = 0;
        m_dout   = '0;
        m_ch     = '0;
        sb_q.delete();
    endtask

    task automatic step(input logic e, input logic [3:0] v, input logic [7:0] base);
        exp_t       x;
        exp_t       got;
        logic [3:0] rdy;
        int         slot;
        int         off;
        en        = e;
        din_valid = v;
        for (int i = 0; i < NCH; i++) din[i*8 +: 8] = base + 8'(i);
        rdy  = '0;
        x.v  = 1'b0;
        x.fs = 1'b0;
        x.ch = m_ch;
        x.d  = m_dout;
        if (m_active != 0) begin
            slot = m_pos / P;
            off  = m_pos % P;
            if (off < SL) begin
                rdy[slot] = 1'b1;
                x.ch      = 2'(slot);
                x.fs      = (m_pos == 0);
                if (v[slot]) begin
                    x.v = 1'b1;
                    x.d = base + 8'(slot);
                end else if (FILL) begin
                    x.v = 1'b1;
                    x.d = 8'h00;
                end
            end
        end
        m_dout = x.d;
        m_ch   = x.ch;
        sb_q.push_back(x);
        if (m_active == 0) begin
            if (e) begin
                m_active = 1;
                m_pos    = 0;
            end
        end else if (m_pos == F - 1) begin
            m_pos = 0;
            if (!e) m_active = 0;
        end else begin
            m_pos++;
        end
        #1;
        check("din_ready", 32'(din_ready), 32'(rdy));
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("dout_valid", 32'(dout_valid), 32'(got.v));
        check("dout_ch", 32'(dout_ch), 32'(got.ch));
        check("frame_start", 32'(frame_start), 32'(got.fs));
        check("dout", 32'(dout), 32'(got.d));
        if (dout_valid) obs_valid++;
        if (frame_start) obs_fs++;
    endtask

    phase_t ph[6];
    int     fs_idx;

    initial begin
        ph[0] = '{"all_valid_2frames", 1'b1, 4'b1111, 8'hA0, 73, 64, 2};
        ph[1] = '{"ch2_only", 1'b1, 4'b0100, 8'h5A, 36, FILL ? 32 : 8, 1};
        ph[2] = '{"en_high_to_slot1", 1'b1, 4'b1111, 8'hA0, 12, 11, 1};
        ph[3] = '{"en_dropped_in_slot1", 1'b0, 4'b1111, 8'hA0, 24, 21, 0};
        ph[4] = '{"idle_en_low", 1'b0, 4'b1111, 8'hA0, 20, 0, 0};
        ph[5] = '{"ch0_ch3_restart", 1'b1, 4'b1001, 8'h30, 37, FILL ? 32 : 16, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_dout_ch", 32'(dout_ch), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_din_ready", 32'(din_ready), 32'h0);
        check("rst_din_ready2", 32'(din_ready2), 32'h0);
        check("rst_dout_valid2", 32'(dout_valid2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int p = 0; p < 6; p++) begin
            obs_valid = 0;
            obs_fs    = 0;
            for (int c = 0; c < ph[p].cycles; c++) step(ph[p].en, ph[p].valid, ph[p].base);
            check({ph[p].name, "_nvalid"}, 32'(obs_valid), 32'(ph[p].exp_nvalid));
            check({ph[p].name, "_nframe_start"}, 32'(obs_fs), 32'(ph[p].exp_nfs));
        end

        // Run into slot 2, cnt 4, then reset asynchronously mid-cycle.
        for (int c = 0; c < 22; c++) step(1'b1, 4'b1111, 8'hA0);
        check("pre_rst_dout_ch", 32'(dout_ch), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout), 32'h0);
        check("async_rst_dout_valid", 32'(dout_valid), 32'h0);
        check("async_rst_dout_ch", 32'(dout_ch), 32'h0);
        check("async_rst_frame_start", 32'(frame_start), 32'h0);
        check("async_rst_din_ready", 32'(din_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fs_idx = -1;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 4'b1111, 8'hA0);
            if (frame_start && fs_idx < 0) begin
                fs_idx = c;
                check("restart_first_word", 32'(dout), 32'hA0);
            end
        end
        check("restart_frame_start_idx", 32'(fs_idx), 32'd1);

        // Back-to-back single-cycle slots on the two-channel instance.
        en2        = 1'b1;
        din_valid2 = 2'b11;
        for (int k = 0; k < 10; k++) begin
            int ch;
            ch = (k + 1) % 2;
            #1;
            check("dut2_din_ready", 32'(din_ready2), (k == 0) ? 32'h0 : 32'(1 << ((k - 1) % 2)));
            @(posedge clk);
            #1;
            if (k == 0) begin
                check("dut2_first_valid", 32'(dout_valid2), 32'h0);
            end else begin
                ch = (k - 1) % 2;
                check("dut2_dout_valid", 32'(dout_valid2), 32'h1);
                check("dut2_dout_ch", 32'(dout_ch2), 32'(ch));
                check("dut2_frame_start", 32'(frame_start2), (ch == 0) ? 32'h1 : 32'h0);
                check("dut2_dout", 32'(dout2), 32'h10 + 32'(ch));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
